// File: rtl/mdio_slave_if.sv
`timescale 1ns/1ps
// MDIO pad pair, strap and register-bank strobe bundle for the Clause-22 responder.
// The slave modport is the responder's view; master is the bus-driver / register-bank side.
interface mdio_slave_if;
   logic        mdc_i;
   logic        mdio_i;
   logic        mdio_o;
   logic        mdio_t;
   logic [4:0]  phy_addr;
   logic [4:0]  reg_addr;
   logic        reg_rd_en;
   logic [15:0] reg_rd_data;
   logic        reg_wr_en;
   logic [15:0] reg_wr_data;
   logic        busy;
   logic        frame_err;

   modport slave (
      input  mdc_i, mdio_i, phy_addr, reg_rd_data,
      output mdio_o, mdio_t, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy, frame_err
   );

   modport master (
      output mdc_i, mdio_i, phy_addr, reg_rd_data,
      input  mdio_o, mdio_t, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy, frame_err
   );
endinterface

// File: rtl/mdio_slave.sv
`timescale 1ns/1ps
// Clause-22 MDIO responder: oversampled MDC/MDIO frames for the strapped PHY become register strobes.
// Outputs move a few clk125 cycles after each MDC rise; no backpressure, the bank answers reads one cycle after reg_rd_en.
module mdio_slave #(
   parameter int PREAMBLE_MIN = 32,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk125,
   input  logic        reset,
   mdio_slave_if.slave mdio
);
   typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA1, TA2, DATA} state_t;

   localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

   logic [SYNC_STAGES-1:0] mdcSync;
   logic [SYNC_STAGES-1:0] mdioSync;
   logic                   mdcPrev;
   logic                   mdcRise;
   logic                   mdioBit;

   state_t      state, stateNxt;
   logic [5:0]  preCnt, preCntNxt;
   logic [3:0]  bitCnt, bitCntNxt;
   logic [15:0] shReg, shRegNxt;
   logic [15:0] shIn;
   logic [4:0]  phyAd, phyAdNxt;
   logic        isRead, isReadNxt;
   logic        match, matchNxt;
   logic        capPend;
   logic        mdioO, mdioONxt;
   logic        mdioT, mdioTNxt;
   logic [4:0]  regAddr, regAddrNxt;
   logic [15:0] wrData, wrDataNxt;
   logic        rdEn, rdEnNxt;
   logic        wrEn, wrEnNxt;
   logic        busyR, busyNxt;
   logic        frameErr, frameErrNxt;

   // mdioBit is delayed alongside the edge detect so it is the value present at the MDC rise
   always_ff @(posedge clk125 or posedge reset) begin
      if (reset) begin
         mdcSync  <= '0;
         mdioSync <= '1;
         mdcPrev  <= 1'b0;
         mdcRise  <= 1'b0;
         mdioBit  <= 1'b1;
      end else begin
         mdcSync  <= {mdcSync[SYNC_STAGES-2:0], mdio.mdc_i};
         mdioSync <= {mdioSync[SYNC_STAGES-2:0], mdio.mdio_i};
         mdcPrev  <= mdcSync[SYNC_STAGES-1];
         mdcRise  <= mdcSync[SYNC_STAGES-1] & ~mdcPrev;
         mdioBit  <= mdioSync[SYNC_STAGES-1];
      end
   end

   assign shIn = {shReg[14:0], mdioBit};

   always_ff @(posedge clk125 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         preCnt   <= '0;
         bitCnt   <= '0;
         shReg    <= '0;
         phyAd    <= '0;
         isRead   <= 1'b0;
         match    <= 1'b0;
         capPend  <= 1'b0;
         mdioO    <= 1'b0;
         mdioT    <= 1'b1;
         regAddr  <= '0;
         wrData   <= '0;
         rdEn     <= 1'b0;
         wrEn     <= 1'b0;
         busyR    <= 1'b0;
         frameErr <= 1'b0;
      end else begin
         state    <= stateNxt;
         preCnt   <= preCntNxt;
         bitCnt   <= bitCntNxt;
         shReg    <= shRegNxt;
         phyAd    <= phyAdNxt;
         isRead   <= isReadNxt;
         match    <= matchNxt;
         capPend  <= rdEn;
         mdioO    <= mdioONxt;
         mdioT    <= mdioTNxt;
         regAddr  <= regAddrNxt;
         wrData   <= wrDataNxt;
         rdEn     <= rdEnNxt;
         wrEn     <= wrEnNxt;
         busyR    <= busyNxt;
         frameErr <= frameErrNxt;
      end
   end

   always_comb begin
      stateNxt    = state;
      preCntNxt   = preCnt;
      bitCntNxt   = bitCnt;
      shRegNxt    = capPend ? mdio.reg_rd_data : shReg;
      phyAdNxt    = phyAd;
      isReadNxt   = isRead;
      matchNxt    = match;
      mdioONxt    = mdioO;
      mdioTNxt    = mdioT;
      regAddrNxt  = regAddr;
      wrDataNxt   = wrData;
      rdEnNxt     = 1'b0;
      wrEnNxt     = 1'b0;
      busyNxt     = busyR;
      frameErrNxt = 1'b0;

      if (mdcRise) begin
         case (state)
            IDLE: begin
               if (mdioBit) begin
                  if (preCnt < PRE_MIN) preCntNxt = preCnt + 6'd1;
               end else if (preCnt >= PRE_MIN) begin
                  stateNxt  = ST;
                  busyNxt   = 1'b1;
                  preCntNxt = '0;
               end else begin
                  preCntNxt = '0;
               end
            end
            ST: begin
               if (mdioBit) begin
                  stateNxt  = OP;
                  bitCntNxt = '0;
               end else begin
                  stateNxt    = IDLE;
                  busyNxt     = 1'b0;
                  frameErrNxt = 1'b1;
               end
            end
            OP: begin
               shRegNxt = shIn;
               if (bitCnt == 4'd0) begin
                  bitCntNxt = 4'd1;
               end else begin
                  bitCntNxt = '0;
                  case ({shReg[0], mdioBit})
                     2'b10: begin
                        isReadNxt = 1'b1;
                        stateNxt  = PHYAD;
                     end
                     2'b01: begin
                        isReadNxt = 1'b0;
                        stateNxt  = PHYAD;
                     end
                     default: begin
                        stateNxt    = IDLE;
                        busyNxt     = 1'b0;
                        frameErrNxt = 1'b1;
                     end
                  endcase
               end
            end
            PHYAD: begin
               shRegNxt = shIn;
               if (bitCnt == 4'd4) begin
                  phyAdNxt  = shIn[4:0];
                  bitCntNxt = '0;
                  stateNxt  = REGAD;
               end else begin
                  bitCntNxt = bitCnt + 4'd1;
               end
            end
            REGAD: begin
               shRegNxt = shIn;
               if (bitCnt == 4'd4) begin
                  bitCntNxt = '0;
                  stateNxt  = TA1;
                  matchNxt  = (phyAd == mdio.phy_addr);
                  if (phyAd == mdio.phy_addr) begin
                     regAddrNxt = shIn[4:0];
                     rdEnNxt    = isRead;
                  end
               end else begin
                  bitCntNxt = bitCnt + 4'd1;
               end
            end
            TA1: begin
               stateNxt = TA2;
               if (isRead && match) begin
                  mdioTNxt = 1'b0;
                  mdioONxt = 1'b0;
               end
            end
            TA2: begin
               if (!isRead && match && mdioBit) begin
                  stateNxt    = IDLE;
                  busyNxt     = 1'b0;
                  frameErrNxt = 1'b1;
               end else begin
                  stateNxt  = DATA;
                  bitCntNxt = '0;
                  if (isRead && match) begin
                     mdioONxt = shReg[15];
                     shRegNxt = {shReg[14:0], 1'b0};
                  end
               end
            end
            DATA: begin
               if (isRead) begin
                  // last data bit was put on the wire at the previous rise; release now
                  if (match) begin
                     if (bitCnt == 4'd15) begin
                        mdioTNxt = 1'b1;
                        mdioONxt = 1'b0;
                     end else begin
                        mdioONxt = shReg[15];
                        shRegNxt = {shReg[14:0], 1'b0};
                     end
                  end
               end else begin
                  shRegNxt = shIn;
                  if (match && bitCnt == 4'd15) begin
                     wrEnNxt   = 1'b1;
                     wrDataNxt = shIn;
                  end
               end
               if (bitCnt == 4'd15) begin
                  stateNxt  = IDLE;
                  busyNxt   = 1'b0;
                  preCntNxt = '0;
               end else begin
                  bitCntNxt = bitCnt + 4'd1;
               end
            end
            default: begin
               stateNxt = IDLE;
               busyNxt  = 1'b0;
            end
         endcase
      end
   end

   assign mdio.mdio_o      = mdioO;
   assign mdio.mdio_t      = mdioT;
   assign mdio.reg_addr    = regAddr;
   assign mdio.reg_rd_en   = rdEn;
   assign mdio.reg_wr_en   = wrEn;
   assign mdio.reg_wr_data = wrData;
   assign mdio.busy        = busyR;
   assign mdio.frame_err   = frameErr;
endmodule

// File: tb/tb_mdio_slave.sv
`timescale 1ns/1ps
// Bench for mdio_slave: a bus master sends directed and random Clause-22 frames; a frame-level
// register model predicts strobes and read data, which two independent monitors check.
module tb_mdio_slave;
   localparam int PRE = 32;

   logic clk125 = 1'b0;
   logic reset  = 1'b1;
   logic mstDrv = 1'b1;
   int   half   = 8;
   int   checks = 0;
   int   errors = 0;
   logic busySeen = 1'b0;

   logic [15:0] bank  [32];
   logic [15:0] model [32];

   typedef struct {
      int          kind;   // 0 write, 1 read, 2 frame error
      logic [4:0]  addr;
      logic [15:0] data;
   } ev_t;

   ev_t         expQ[$];
   logic [15:0] busQ[$];

   mdio_slave_if mdio();

   mdio_slave #(.PREAMBLE_MIN(PRE), .SYNC_STAGES(2)) dut (
      .clk125 (clk125),
      .reset  (reset),
      .mdio   (mdio)
   );

   always #4 clk125 = ~clk125;

   // open-drain bus with pull-up: the responder wins whenever it drives
   assign mdio.mdio_i = mdio.mdio_t ? mstDrv : mdio.mdio_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushEv(input int k, input logic [4:0] a, input logic [15:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      expQ.push_back(e);
   endtask

   task automatic mdcBit(input logic b, input logic drive);
      mstDrv = drive ? b : 1'b1;
      repeat (half) @(negedge clk125);
      mdio.mdc_i = 1'b1;
      repeat (half) @(negedge clk125);
      mdio.mdc_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) mdcBit(1'b1, 1'b1);
   endtask

   // abortAt >= 0 stops with MDC high just after that data bit's rising edge
   task automatic sendFrame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] d, input logic [1:0] ta,
                            input int abortAt);
      logic rd;
      rd = (op == 2'b10);
      for (int i = 0; i < pre; i++) mdcBit(1'b1, 1'b1);
      mdcBit(1'b0, 1'b1);
      mdcBit(1'b1, 1'b1);
      for (int i = 1; i >= 0; i--) mdcBit(op[i], 1'b1);
      for (int i = 4; i >= 0; i--) mdcBit(phy[i], 1'b1);
      for (int i = 4; i >= 0; i--) mdcBit(rg[i], 1'b1);
      mdcBit(ta[1], !rd);
      mdcBit(ta[0], !rd);
      for (int i = 15; i >= 0; i--) begin
         if (15 - i == abortAt) begin
            mstDrv = 1'b1;
            repeat (half) @(negedge clk125);
            mdio.mdc_i = 1'b1;
            repeat (6) @(negedge clk125);
            return;
         end
         mdcBit(d[i], !rd);
      end
   endtask

   task automatic doWrite(input int pre, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
      if (pre >= PRE && phy == mdio.phy_addr) begin
         pushEv(0, rg, d);
         model[rg] = d;
      end
      sendFrame(pre, 2'b01, phy, rg, d, 2'b10, -1);
   endtask

   task automatic doRead(input int pre, input logic [4:0] phy, input logic [4:0] rg);
      if (pre >= PRE && phy == mdio.phy_addr) begin
         pushEv(1, rg, 16'h0);
         busQ.push_back(model[rg]);
      end
      sendFrame(pre, 2'b10, phy, rg, 16'hFFFF, 2'b11, -1);
   endtask

   // local register bank served by the responder
   initial forever begin
      @(negedge clk125);
      if (mdio.reg_rd_en) mdio.reg_rd_data = bank[mdio.reg_addr];
      if (mdio.reg_wr_en) bank[mdio.reg_addr] = mdio.reg_wr_data;
   end

   // strobe monitor
   initial begin
      ev_t ev;
      int  k;
      forever begin
         @(negedge clk125);
         if (mdio.busy) busySeen = 1'b1;
         if (mdio.reg_wr_en || mdio.reg_rd_en || mdio.frame_err) begin
            chk("strobe_onehot", int'(mdio.reg_wr_en) + int'(mdio.reg_rd_en) + int'(mdio.frame_err), 1);
            k = mdio.reg_wr_en ? 0 : (mdio.reg_rd_en ? 1 : 2);
            if (expQ.size() == 0) begin
               chk("unexpected_strobe", 32'(k) + 32'd1, 0);
            end else begin
               ev = expQ.pop_front();
               chk("strobe_kind", 32'(k), 32'(ev.kind));
               if (ev.kind != 2) chk("strobe_addr", 32'(mdio.reg_addr), 32'(ev.addr));
               if (ev.kind == 0) chk("wr_data", 32'(mdio.reg_wr_data), 32'(ev.data));
            end
         end
      end
   end

   // bus monitor: what a master samples on each MDC rise while the responder drives
   initial begin
      logic [16:0] bits;
      logic [15:0] e;
      int          n;
      bits = '0;
      n    = 0;
      forever begin
         @(posedge mdio.mdc_i or posedge reset);
         if (reset) begin
            n = 0;
         end else if (!mdio.mdio_t) begin
            bits = {bits[15:0], mdio.mdio_i};
            n++;
         end else if (n > 0) begin
            if (busQ.size() == 0) begin
               chk("unexpected_drive", 32'(n), 0);
            end else begin
               e = busQ.pop_front();
               chk("rd_drive_len", 32'(n), 17);
               chk("rd_ta2", 32'(bits[16]), 0);
               chk("rd_data", 32'(bits[15:0]), 32'(e));
            end
            n = 0;
         end
      end
   end

   initial begin
      #700000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      logic [4:0]  rg;
      logic [4:0]  phy;
      mdio.mdc_i       = 1'b0;
      mdio.phy_addr    = 5'd1;
      mdio.reg_rd_data = '0;
      for (int i = 0; i < 32; i++) begin
         v = 16'($urandom);
         bank[i]  = v;
         model[i] = v;
      end

      reset = 1'b1;
      repeat (3) @(negedge clk125);
      chk("rst_mdio_t", 32'(mdio.mdio_t), 1);
      chk("rst_mdio_o", 32'(mdio.mdio_o), 0);
      chk("rst_reg_addr", 32'(mdio.reg_addr), 0);
      chk("rst_wr_data", 32'(mdio.reg_wr_data), 0);
      chk("rst_rd_en", 32'(mdio.reg_rd_en), 0);
      chk("rst_wr_en", 32'(mdio.reg_wr_en), 0);
      chk("rst_busy", 32'(mdio.busy), 0);
      chk("rst_frame_err", 32'(mdio.frame_err), 0);
      reset = 1'b0;
      idle(2);

      busySeen = 1'b0;
      doWrite(32, 5'd1, 5'h04, 16'hABCD);
      idle(2);
      chk("busy_seen_write", 32'(busySeen), 1);

      bank[2]  = 16'h1234;
      model[2] = 16'h1234;
      doRead(32, 5'd1, 5'h02);
      idle(2);

      doWrite(32, 5'd3, 5'h07, 16'hDEAD);
      doRead(32, 5'd3, 5'h07);
      bank[9]  = 16'h5A5A;
      model[9] = 16'h5A5A;
      doRead(32, 5'd1, 5'h09);
      idle(2);

      mdcBit(1'b0, 1'b1);
      busySeen = 1'b0;
      doWrite(20, 5'd1, 5'h0B, 16'h1234);
      idle(2);
      chk("busy_short_preamble", 32'(busySeen), 0);
      doRead(32, 5'd1, 5'h0B);
      idle(2);

      pushEv(2, 5'h0, 16'h0);
      sendFrame(32, 2'b11, 5'd1, 5'h08, 16'h0F0F, 2'b10, -1);
      idle(2);
      pushEv(2, 5'h0, 16'h0);
      sendFrame(32, 2'b01, 5'd1, 5'h08, 16'h00F0, 2'b11, -1);
      idle(2);
      doRead(32, 5'd1, 5'h08);
      idle(2);

      pushEv(1, 5'h03, 16'h0);
      sendFrame(32, 2'b10, 5'd1, 5'h03, 16'hFFFF, 2'b11, 8);
      chk("drive_before_reset", 32'(mdio.mdio_t), 0);
      #1 reset = 1'b1;
      #1;
      chk("reset_release_t", 32'(mdio.mdio_t), 1);
      chk("reset_busy", 32'(mdio.busy), 0);
      @(negedge clk125);
      mdio.mdc_i = 1'b0;
      repeat (4) @(negedge clk125);
      reset = 1'b0;
      idle(2);
      bank[10]  = 16'hFFFF;
      model[10] = 16'hFFFF;
      doRead(32, 5'd1, 5'h0A);
      idle(2);

      half = 8;
      doWrite(32, 5'd1, 5'h05, 16'h0001);
      doWrite(32, 5'd1, 5'h06, 16'h8000);
      idle(2);
      doRead(32, 5'd1, 5'h05);
      doRead(32, 5'd1, 5'h06);
      idle(2);

      mdio.phy_addr = 5'd17;
      for (int i = 0; i < 24; i++) begin
         half = 4 + int'($urandom_range(5, 0));
         rg   = 5'($urandom);
         phy  = ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'd17;
         if ($urandom_range(1, 0) == 1) doWrite(32, phy, rg, 16'($urandom));
         else                           doRead(32, phy, rg);
         idle(1 + int'($urandom_range(2, 0)));
      end
      half = 8;
      idle(2);

      for (int i = 0; i < 400 && (expQ.size() != 0 || busQ.size() != 0); i++) @(negedge clk125);
      chk("strobe_queue_empty", 32'(expQ.size()), 0);
      chk("bus_queue_empty", 32'(busQ.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
